rmii_tx: RTL and testbench
==========================

// Module: rmii_tx
// PURPOSE
//  RMII 100 Mb/s transmitter: pops frame bytes (header, body, FCS) from the
//  egress FIFO, prepends preamble+SFD, and drives TX_EN/TXD[1:0] to the PHY.
//  It is the egress counterpart of the RMII receive path in the L2 switch.
//  The FCS is forwarded unchanged and never generated here.
//  It enforces the inter-frame gap and handles FIFO underrun by aborting the
//  frame and draining the rest of it.
// PARAMETERS
//  IFG_CYCLES      48  REF_CLK cycles with TX_EN low after each frame (96 bit times)
//  PREAMBLE_DIBITS 31  count of (TXD0,TXD1)=(1,0) dibits sent before the final SFD dibit (1,1)
// PORTS
//  REF_CLK             in   1   50 MHz RMII reference clock; all logic on its rising edge
//  arst_n              in   1   asynchronous, active-low reset
//  fifo_empty          in   1   egress FIFO empty (FIFO is first-word-fall-through)
//  fifo_dout           in   8   head byte; valid when fifo_empty=0
//  fifo_EOD_out        in   1   head byte is the last byte of its frame
//  fifo_rden           out  1   pop the head byte; 1-cycle pulse
//  TX_EN               out  1   RMII transmit enable (registered)
//  TXD0, TXD1          out  1   RMII transmit dibit (registered)
//  succ_tx_count_gray  out  16  frames completed, gray-coded
//  underrun_count_gray out  16  frames aborted by underrun, gray-coded
// BEHAVIOUR
//  Reset state:
//   - STATE=S_IDLE; TX_EN=0, TXD=00, fifo_rden=0.
//   - Both counters are 0; the IFG counter is 0, so the first frame needs no gap.
//  Bit order (mirrors the receiver's byte packing):
//   - Byte b goes out MSB-pair first as dibits {TXD0,TXD1} = b[7:6], b[5:4], b[3:2], b[1:0].
//  States: S_IDLE, S_PREAMBLE, S_BODY, S_DRAIN, S_IFG (3-bit encoding).
//   - Any undefined encoding goes to S_IFG with TX_EN=0.
//  S_IDLE:
//   - When fifo_empty=0: go to S_PREAMBLE.
//   - TX_EN=1 and TXD=10 on the next edge (1-cycle latency).
//  S_PREAMBLE:
//   - Send PREAMBLE_DIBITS dibits of 10, then one dibit of 11 (SFD end).
//   - 32 cycles in total at the defaults.
//   - fifo_rden=1 in the final SFD cycle; fifo_dout is captured into the shift register.
//   - The first body dibit follows the SFD dibit with no gap.
//  S_BODY:
//   - A 2-bit dibit counter paces exactly 4 cycles per byte.
//   - In the 4th dibit cycle of each byte, at the capture point:
//     - if the current byte had EOD=1: no pop. TX_EN=0 on the next edge,
//       succ_tx_count+1, go to S_IFG.
//     - else if fifo_empty=0: fifo_rden=1 and capture the next byte (contiguous TXD).
//     - else (underrun): TX_EN=0 on the next edge, underrun_count+1, go to S_DRAIN.
//   - The EOD flag is captured together with each byte.
//  S_DRAIN:
//   - TX_EN=0.
//   - fifo_rden=1 in each cycle that fifo_empty=0, until a byte with
//     fifo_EOD_out=1 is popped; then go to S_IFG.
//  S_IFG:
//   - TX_EN=0, TXD=00.
//   - Count IFG_CYCLES cycles, then go to S_IDLE. Frames are never started during the IFG.
//  Rules that hold in every state:
//   - fifo_rden is never asserted when fifo_empty=1.
//   - There is at most one pop per 4 cycles in S_BODY.
//   - TXD=00 whenever TX_EN=0.
//  Counters:
//   - 16-bit binary, wrap at 0xFFFF->0.
//   - Output through binary-to-gray conversion for CDC to the user domain.
//  Reset mid-frame:
//   - TX_EN drops asynchronously; the frame is truncated.
//   - The FIFO is not drained by this block.
//  Single-byte frame (EOD on the first byte): 32 preamble cycles, 4 body cycles, then S_IFG.
// TESTING
//  1. Reset, then a 64-byte frame in the FIFO (bytes 0x00..0x3F, EOD on 0x3F):
//     -> 31x(1,0), (1,1), then 256 body dibits; TX_EN high for 288 cycles; succ=1 (gray 0x0001).
//  2. Byte 0xB4 -> TXD sequence 10,11,01,00; fifo_rden pulses exactly 64 times, 4 cycles apart.
//  3. Two back-to-back frames already queued -> TX_EN low for exactly 48 cycles between
//     frames; succ=2 (gray 0x0003).
//  4. FIFO empties after 10 of 20 bytes -> TX_EN falls after byte 10; underrun=1; the
//     remaining 10 bytes are popped without transmission; the next frame starts only
//     after EOD plus the IFG.
//  5. arst_n pulsed low during byte 5 of the body -> TX_EN=0 and TXD=00 immediately;
//     both counters=0; S_IDLE.
//  6. Force 0xFFFF frames (or preload the counter) -> the next success wraps succ to 0
//     (gray 0x0000).

Source files
------------

// File: rtl/rmii_tx_if.sv
// Egress FIFO read port as seen by the RMII transmitter (first-word-fall-through).
// master = FIFO side driving the head byte, slave = the transmitter popping it.
interface rmii_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_EOD_out;
  logic       fifo_rden;

  modport master (
    output fifo_empty,
    output fifo_dout,
    output fifo_EOD_out,
    input  fifo_rden
  );

  modport slave (
    input  fifo_empty,
    input  fifo_dout,
    input  fifo_EOD_out,
    output fifo_rden
  );
endinterface

// File: rtl/rmii_tx.sv
// RMII 100 Mb/s transmitter: preamble+SFD, MSB-pair-first byte serialisation,
// inter-frame gap, and underrun abort with drain of the rest of the frame.
module rmii_tx #(
  parameter int unsigned IFG_CYCLES      = 48,
  parameter int unsigned PREAMBLE_DIBITS = 31
) (
  input  logic        REF_CLK,
  input  logic        arst_n,
  rmii_tx_if.slave    fifo,
  output logic        TX_EN,
  output logic        TXD0,
  output logic        TXD1,
  output logic [15:0] succ_tx_count_gray,
  output logic [15:0] underrun_count_gray
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_BODY     = 3'd2,
    S_DRAIN    = 3'd3,
    S_IFG      = 3'd4
  } state_t;

  localparam int unsigned PW = $clog2(PREAMBLE_DIBITS + 1);
  localparam int unsigned IW = $clog2(IFG_CYCLES);
  localparam logic [PW-1:0] PRE_SFD  = PW'(PREAMBLE_DIBITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_DIBITS - 1);
  // The IDLE cycle that launches the next frame is the final gap cycle,
  // so the IFG state itself lasts one cycle less than the gap.
  localparam logic [IW-1:0] IFG_LOAD = IW'(IFG_CYCLES - 2);

  state_t          state, state_d;
  logic [PW-1:0]   pre_cnt;
  logic [1:0]      dcnt;
  logic [IW-1:0]   ifg_cnt;
  logic [5:0]      shreg;
  logic            eod_r;
  logic [15:0]     succ_cnt, und_cnt;
  logic [15:0]     succ_nx, und_nx;

  logic            tx_en_d;
  logic [1:0]      txd_d;
  logic            load;
  logic            succ_inc;
  logic            und_inc;
  logic            pre_sfd;
  logic            byte_end;

  assign pre_sfd  = (pre_cnt == PRE_SFD);
  assign byte_end = (dcnt == 2'd3);
  assign succ_nx  = succ_cnt + 16'd1;
  assign und_nx   = und_cnt + 16'd1;

  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) state <= S_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:     if (!fifo.fifo_empty) state_d = S_PREAMBLE;
      S_PREAMBLE: if (pre_sfd) state_d = fifo.fifo_empty ? S_DRAIN : S_BODY;
      S_BODY: begin
        if (byte_end) begin
          if (eod_r)                 state_d = S_IFG;
          else if (fifo.fifo_empty)  state_d = S_DRAIN;
        end
      end
      S_DRAIN:    if (!fifo.fifo_empty && fifo.fifo_EOD_out) state_d = S_IFG;
      S_IFG:      if (ifg_cnt == '0) state_d = S_IDLE;
      default:    state_d = S_IFG;
    endcase
  end

  // tx_en_d/txd_d are the values the output flops take at the next edge.
  always_comb begin
    fifo.fifo_rden = 1'b0;
    tx_en_d        = 1'b0;
    txd_d          = 2'b00;
    load           = 1'b0;
    succ_inc       = 1'b0;
    und_inc        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo.fifo_empty) begin
          tx_en_d = 1'b1;
          txd_d   = 2'b10;
        end
      end
      S_PREAMBLE: begin
        if (!pre_sfd) begin
          tx_en_d = 1'b1;
          txd_d   = (pre_cnt == PRE_LAST) ? 2'b11 : 2'b10;
        end else if (!fifo.fifo_empty) begin
          fifo.fifo_rden = 1'b1;
          load           = 1'b1;
          tx_en_d        = 1'b1;
          txd_d          = fifo.fifo_dout[7:6];
        end else begin
          und_inc = 1'b1;
        end
      end
      S_BODY: begin
        if (!byte_end) begin
          tx_en_d = 1'b1;
          txd_d   = shreg[5:4];
        end else if (eod_r) begin
          succ_inc = 1'b1;
        end else if (!fifo.fifo_empty) begin
          fifo.fifo_rden = 1'b1;
          load           = 1'b1;
          tx_en_d        = 1'b1;
          txd_d          = fifo.fifo_dout[7:6];
        end else begin
          und_inc = 1'b1;
        end
      end
      S_DRAIN: fifo.fifo_rden = !fifo.fifo_empty;
      default: ;
    endcase
  end

  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      TX_EN               <= 1'b0;
      TXD0                <= 1'b0;
      TXD1                <= 1'b0;
      pre_cnt             <= '0;
      dcnt                <= '0;
      ifg_cnt             <= '0;
      shreg               <= '0;
      eod_r               <= 1'b0;
      succ_cnt            <= '0;
      und_cnt             <= '0;
      succ_tx_count_gray  <= '0;
      underrun_count_gray <= '0;
    end else begin
      TX_EN        <= tx_en_d;
      {TXD0, TXD1} <= txd_d;
      pre_cnt      <= (state == S_PREAMBLE) ? pre_cnt + PW'(1) : '0;
      dcnt         <= (state == S_BODY) ? dcnt + 2'd1 : '0;

      // Bits 7:6 go straight to TXD on capture; only the lower three dibits are held.
      if (load) begin
        shreg <= fifo.fifo_dout[5:0];
        eod_r <= fifo.fifo_EOD_out;
      end else if (state == S_BODY) begin
        shreg <= {shreg[3:0], 2'b00};
      end

      if (state_d == S_IFG && state != S_IFG)
        ifg_cnt <= IFG_LOAD;
      else if (state == S_IFG && ifg_cnt != '0)
        ifg_cnt <= ifg_cnt - IW'(1);

      if (succ_inc) begin
        succ_cnt           <= succ_nx;
        succ_tx_count_gray <= succ_nx ^ (succ_nx >> 1);
      end
      if (und_inc) begin
        und_cnt             <= und_nx;
        underrun_count_gray <= und_nx ^ (und_nx >> 1);
      end
    end
  end

endmodule

// File: tb/tb_rmii_tx.sv
// Directed bench for rmii_tx: FWFT FIFO model, line monitor, frame vector table
// plus hand sequences for gap, drain, mid-frame reset and counter wrap.
module tb_rmii_tx;
  logic        clk = 1'b0;
  logic        arst_n;
  logic        TX_EN, TXD0, TXD1;
  logic [15:0] succ_g, und_g;

  always #10 clk = ~clk;

  rmii_tx_if fifo_if ();

  rmii_tx #(.IFG_CYCLES(48), .PREAMBLE_DIBITS(31)) dut (
    .REF_CLK            (clk),
    .arst_n             (arst_n),
    .fifo               (fifo_if.slave),
    .TX_EN              (TX_EN),
    .TXD0               (TXD0),
    .TXD1               (TXD1),
    .succ_tx_count_gray (succ_g),
    .underrun_count_gray(und_g)
  );

  // FIFO model: main writes mem/wr_ptr/flush_to, this process owns rd_ptr.
  logic [8:0] mem [0:1023];
  int wr_ptr = 0, rd_ptr = 0, flush_to = 0;
  bit pop_req = 1'b0;

  initial begin
    fifo_if.fifo_empty   = 1'b1;
    fifo_if.fifo_dout    = '0;
    fifo_if.fifo_EOD_out = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (flush_to > rd_ptr)                rd_ptr = flush_to;
      else if (pop_req && rd_ptr < wr_ptr)  rd_ptr++;
      fifo_if.fifo_empty = (rd_ptr == wr_ptr);
      {fifo_if.fifo_EOD_out, fifo_if.fifo_dout} = mem[rd_ptr % 1024];
    end
  end

  // Line monitor, sampled on the falling edge.
  int cyc = 0, pops = 0, bursts = 0, burst_len = 0, last_burst = 0;
  int low_run = 0, gap = 0, eod_pop_cyc = -1000, eod_to_rise = 0, last_pop = -1;
  int idle_err = 0, rden_err = 0, spacing_err = 0;
  bit prev_en = 1'b0;
  logic [1:0] dq [$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (TX_EN === 1'b1) begin
      if (!prev_en) begin
        gap         = low_run;
        eod_to_rise = cyc - eod_pop_cyc;
        burst_len   = 0;
        last_pop    = -1;
      end
      burst_len++;
      dq.push_back({TXD0, TXD1});
    end else begin
      if (TXD0 !== 1'b0 || TXD1 !== 1'b0) idle_err++;
      if (prev_en) begin
        last_burst = burst_len;
        bursts++;
        low_run = 0;
      end
      low_run++;
    end
    if (fifo_if.fifo_rden === 1'b1) begin
      pops++;
      if (fifo_if.fifo_empty) rden_err++;
      if (fifo_if.fifo_EOD_out) eod_pop_cyc = cyc;
      if (TX_EN === 1'b1) begin
        if (last_pop >= 0 && cyc - last_pop != 4) spacing_err++;
        last_pop = cyc;
      end
    end
    pop_req = (fifo_if.fifo_rden === 1'b1) && !fifo_if.fifo_empty;
    prev_en = (TX_EN === 1'b1);
  end

  int n_vec = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_range(input logic [7:0] base, input int first, input int last, input int n);
    for (int i = first; i < last; i++) begin
      mem[wr_ptr % 1024] = {(i == n - 1), base + 8'(i)};
      wr_ptr++;
    end
  endtask

  task automatic wait_bursts(input int target, input string name);
    int k = 0;
    while (bursts < target && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (bursts < target) check({name, " frame timeout"}, 0, 1);
  endtask

  task automatic wait_empty(input string name);
    int k = 0;
    while (rd_ptr != wr_ptr && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (rd_ptr != wr_ptr) check({name, " drain timeout"}, 0, 1);
  endtask

  task automatic check_payload(input string name, input int base_idx, input logic [7:0] b0, input int nb);
    int bad = 0;
    logic [1:0] e;
    logic [7:0] by;
    for (int i = 0; i < 32 + 4 * nb; i++) begin
      if (i < 31)       e = 2'b10;
      else if (i == 31) e = 2'b11;
      else begin
        by = b0 + 8'((i - 32) / 4);
        case ((i - 32) % 4)
          0:       e = by[7:6];
          1:       e = by[5:4];
          2:       e = by[3:2];
          default: e = by[1:0];
        endcase
      end
      if (base_idx + i >= dq.size()) bad++;
      else if (dq[base_idx + i] !== e) bad++;
    end
    check({name, " dibit errors"}, bad, 0);
  endtask

  typedef struct {
    string      name;
    logic [7:0] base;
    int         nbytes;
    int         avail;
    int         exp_txen;
    int         exp_pops;
    logic [15:0] exp_succ_g;
    logic [15:0] exp_und_g;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int dq0, p0, b0, k;
    vecs[0] = '{"frame64",       8'h00, 64, 64, 288, 64, 16'h0001, 16'h0000};
    vecs[1] = '{"single_B4",     8'hB4,  1,  1,  36,  1, 16'h0003, 16'h0000};
    vecs[2] = '{"underrun10of20",8'h40, 20, 10,  72, 20, 16'h0003, 16'h0001};
    vecs[3] = '{"frame5",        8'hA0,  5,  5,  52,  5, 16'h0002, 16'h0001};
    vecs[4] = '{"underrun1of2",  8'hC0,  2,  1,  36,  2, 16'h0002, 16'h0003};

    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset TX_EN", int'(TX_EN), 0);
    check("reset TXD", int'({TXD0, TXD1}), 0);
    check("reset rden", int'(fifo_if.fifo_rden), 0);
    check("reset succ gray", int'(succ_g), 0);
    check("reset underrun gray", int'(und_g), 0);

    for (int v = 0; v < 5; v++) begin
      dq0 = dq.size(); p0 = pops; b0 = bursts;
      push_range(vecs[v].base, 0, vecs[v].avail, vecs[v].nbytes);
      wait_bursts(b0 + 1, vecs[v].name);
      if (vecs[v].avail < vecs[v].nbytes)
        push_range(vecs[v].base, vecs[v].avail, vecs[v].nbytes, vecs[v].nbytes);
      wait_empty(vecs[v].name);
      repeat (60) @(negedge clk);
      check({vecs[v].name, " TX_EN cycles"}, last_burst, vecs[v].exp_txen);
      check({vecs[v].name, " pops"}, pops - p0, vecs[v].exp_pops);
      check({vecs[v].name, " succ gray"}, int'(succ_g), int'(vecs[v].exp_succ_g));
      check({vecs[v].name, " underrun gray"}, int'(und_g), int'(vecs[v].exp_und_g));
      check_payload(vecs[v].name, dq0, vecs[v].base, vecs[v].avail);
    end

    // Two frames queued back to back: gap must be exactly the IFG.
    b0 = bursts;
    push_range(8'h11, 0, 3, 3);
    push_range(8'h21, 0, 3, 3);
    wait_bursts(b0 + 2, "b2b");
    check("b2b TX_EN low gap", gap, 48);
    repeat (60) @(negedge clk);
    check("b2b succ gray", int'(succ_g), 16'h0007);

    // Underrun, then the rest of that frame and a new frame arrive together.
    b0 = bursts;
    push_range(8'h30, 0, 3, 6);
    wait_bursts(b0 + 1, "drain");
    push_range(8'h30, 3, 6, 6);
    push_range(8'h50, 0, 2, 2);
    wait_bursts(b0 + 2, "drain next");
    check("drain EOD pop to next TX_EN", eod_to_rise, 49);
    check("drain underrun gray", int'(und_g), 16'h0002);
    repeat (60) @(negedge clk);
    check("drain succ gray", int'(succ_g), 16'h0005);

    // Reset asserted during the fifth body byte.
    push_range(8'h70, 0, 10, 10);
    k = 0;
    while (TX_EN !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (TX_EN !== 1'b1) check("midreset start timeout", 0, 1);
    repeat (31 + 16 + 2) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    check("midreset TX_EN", int'(TX_EN), 0);
    check("midreset TXD", int'({TXD0, TXD1}), 0);
    check("midreset rden", int'(fifo_if.fifo_rden), 0);
    check("midreset succ gray", int'(succ_g), 0);
    check("midreset underrun gray", int'(und_g), 0);
    flush_to = wr_ptr;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("after reset TX_EN", int'(TX_EN), 0);

    // Counter wrap: preload 0xFFFF, next success goes to 0.
    @(negedge clk);
    force dut.succ_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.succ_cnt;
    b0 = bursts;
    push_range(8'h99, 0, 1, 1);
    wait_bursts(b0 + 1, "wrap");
    repeat (60) @(negedge clk);
    check("wrap succ gray", int'(succ_g), 16'h0000);
    push_range(8'h9A, 0, 1, 1);
    wait_bursts(b0 + 2, "wrap next");
    repeat (60) @(negedge clk);
    check("post-wrap succ gray", int'(succ_g), 16'h0001);

    check("TXD nonzero while TX_EN low", idle_err, 0);
    check("rden while FIFO empty", rden_err, 0);
    check("body pop spacing", spacing_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
